// File: rtl/key_expansion.sv
// AES-128 key schedule: expands a 128-bit cipher key into 11 round keys,
// producing one round key per clock after a start request.
module key_expansion (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [127:0]    key,
    output logic [1407:0]   expanded_key,
    output logic            busy,
    output logic            finish
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] top_bit;
        top_bit = 11'd2047 - {b, 3'b000};
        return SBOX_TABLE[top_bit -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    state_t         state_r;
    state_t         state_next_s;
    logic [3:0]     rc_r;
    logic [3:0]     rc_next_s;
    logic [1407:0]  expanded_key_r;
    logic [1407:0]  expanded_key_next_s;
    logic [127:0]   last_r;
    logic [127:0]   last_next_s;
    logic           busy_r;
    logic           busy_next_s;
    logic           finish_r;
    logic           finish_next_s;

    logic [31:0]    rot_s;
    logic [31:0]    temp_s;
    logic [31:0]    w0_s;
    logic [31:0]    w1_s;
    logic [31:0]    w2_s;
    logic [31:0]    w3_s;
    logic [127:0]   round_key_s;

    // One FIPS-197 round step applied to the previous round key held in last_r.
    always_comb begin
        rot_s       = {last_r[23:0], last_r[31:24]};
        temp_s      = sub_word(rot_s) ^ {rcon(rc_r), 24'h000000};
        w0_s        = last_r[127:96] ^ temp_s;
        w1_s        = last_r[95:64]  ^ w0_s;
        w2_s        = last_r[63:32]  ^ w1_s;
        w3_s        = last_r[31:0]   ^ w2_s;
        round_key_s = {w0_s, w1_s, w2_s, w3_s};
    end

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r        <= IDLE;
            rc_r           <= 4'd0;
            expanded_key_r <= 1408'd0;
            last_r         <= 128'd0;
            busy_r         <= 1'b0;
            finish_r       <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            rc_r           <= rc_next_s;
            expanded_key_r <= expanded_key_next_s;
            last_r         <= last_next_s;
            busy_r         <= busy_next_s;
            finish_r       <= finish_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = EXPAND;
                end else begin
                    state_next_s = IDLE;
                end
            end
            EXPAND: begin
                if (rc_r == 4'd10) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = EXPAND;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Datapath and output next values. Slices above rc are zero while
    // expanding, so OR-ing the new round key into place writes slice rc.
    always_comb begin
        rc_next_s           = rc_r;
        expanded_key_next_s = expanded_key_r;
        last_next_s         = last_r;
        busy_next_s         = busy_r;
        finish_next_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    expanded_key_next_s = {1280'd0, key};
                    last_next_s         = key;
                    rc_next_s           = 4'd1;
                    busy_next_s         = 1'b1;
                end else begin
                    busy_next_s         = 1'b0;
                end
            end
            EXPAND: begin
                expanded_key_next_s = expanded_key_r |
                                      ({1280'd0, round_key_s} << {rc_r, 7'd0});
                last_next_s         = round_key_s;
                if (rc_r == 4'd10) begin
                    rc_next_s     = 4'd0;
                    busy_next_s   = 1'b0;
                    finish_next_s = 1'b1;
                end else begin
                    rc_next_s     = rc_r + 4'd1;
                    busy_next_s   = 1'b1;
                end
            end
            default: begin
                rc_next_s   = 4'd0;
                busy_next_s = 1'b0;
            end
        endcase
    end

    assign expanded_key = expanded_key_r;
    assign busy         = busy_r;
    assign finish       = finish_r;

endmodule

// File: tb/tb_key_expansion.sv
// Directed testbench for key_expansion using FIPS-197 reference round keys.
module tb_key_expansion;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R2   = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] FIPS_R9   = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] FIPS_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_KEY  = 128'h0;
    localparam logic [127:0] ZERO_R1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R2   = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    localparam logic [127:0] ZERO_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic           clk;
    logic           rst;
    logic           start;
    logic [127:0]   key;
    logic [1407:0]  expanded_key;
    logic           busy;
    logic           finish;

    int tests_run;
    int tests_failed;

    key_expansion dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .key          (key),
        .expanded_key (expanded_key),
        .busy         (busy),
        .finish       (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] slice(input int r);
        return expanded_key[r*128 +: 128];
    endfunction

    // Presents start for one edge; returns at the negedge after the accepting edge.
    task automatic accept(input logic [127:0] k);
        @(negedge clk);
        key   = k;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Observes n cycles after acceptance; records finish indices and busy drop.
    task automatic watch(input int n, output int f1, output int f2,
                         output int fcnt, output int bdrop);
        f1 = -1; f2 = -1; fcnt = 0; bdrop = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (finish === 1'b1) begin
                fcnt++;
                if (f1 < 0) f1 = i;
                else if (f2 < 0) f2 = i;
            end
            if (busy !== 1'b1 && bdrop < 0) bdrop = i;
        end
    endtask

    task automatic test_reset;
        rst   = 1'b0;
        start = 1'b1;
        key   = FIPS_KEY;
        repeat (3) @(negedge clk);
        tests_run++;
        if (expanded_key !== 1408'd0) begin
            tests_failed++; $display("FAIL reset_key: got %h.. required 0", expanded_key[127:0]);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++; $display("FAIL reset_busy: got %b required 0", busy);
        end
        tests_run++;
        if (finish !== 1'b0) begin
            tests_failed++; $display("FAIL reset_finish: got %b required 0", finish);
        end
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++; $display("FAIL start_lost_in_reset: busy %b required 0", busy);
        end
    endtask

    task automatic test_fips;
        int f1, f2, fcnt, bdrop;
        accept(FIPS_KEY);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++; $display("FAIL fips_busy_set: got %b required 1", busy);
        end
        tests_run++;
        if (slice(0) !== FIPS_KEY) begin
            tests_failed++; $display("FAIL fips_slice0: got %h required %h", slice(0), FIPS_KEY);
        end
        watch(14, f1, f2, fcnt, bdrop);
        tests_run++;
        if (f1 !== 10 || fcnt !== 1) begin
            tests_failed++; $display("FAIL fips_finish: at %0d count %0d required at 10 count 1", f1, fcnt);
        end
        tests_run++;
        if (bdrop !== 10) begin
            tests_failed++; $display("FAIL fips_busy_drop: at %0d required 10", bdrop);
        end
        tests_run++;
        if (slice(1) !== FIPS_R1) begin
            tests_failed++; $display("FAIL fips_slice1: got %h required %h", slice(1), FIPS_R1);
        end
        tests_run++;
        if (slice(2) !== FIPS_R2) begin
            tests_failed++; $display("FAIL fips_slice2: got %h required %h", slice(2), FIPS_R2);
        end
        tests_run++;
        if (slice(9) !== FIPS_R9) begin
            tests_failed++; $display("FAIL fips_slice9: got %h required %h", slice(9), FIPS_R9);
        end
        tests_run++;
        if (slice(10) !== FIPS_R10) begin
            tests_failed++; $display("FAIL fips_slice10: got %h required %h", slice(10), FIPS_R10);
        end
    endtask

    task automatic test_idle_hold;
        logic ok;
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0 || finish !== 1'b0) ok = 1'b0;
        end
        tests_run++;
        if (ok !== 1'b1) begin
            tests_failed++; $display("FAIL idle_flags: busy/finish went high, got %b required 1", ok);
        end
        tests_run++;
        if (slice(0) !== FIPS_KEY || slice(1) !== FIPS_R1 || slice(10) !== FIPS_R10) begin
            tests_failed++; $display("FAIL idle_hold: slice10 %h required %h", slice(10), FIPS_R10);
        end
    endtask

    task automatic test_zero_key;
        int f1, f2, fcnt, bdrop;
        accept(ZERO_KEY);
        watch(12, f1, f2, fcnt, bdrop);
        tests_run++;
        if (f1 !== 10 || fcnt !== 1) begin
            tests_failed++; $display("FAIL zero_finish: at %0d count %0d required at 10 count 1", f1, fcnt);
        end
        tests_run++;
        if (slice(1) !== ZERO_R1) begin
            tests_failed++; $display("FAIL zero_slice1: got %h required %h", slice(1), ZERO_R1);
        end
        tests_run++;
        if (slice(2) !== ZERO_R2) begin
            tests_failed++; $display("FAIL zero_slice2: got %h required %h", slice(2), ZERO_R2);
        end
        tests_run++;
        if (slice(10) !== ZERO_R10) begin
            tests_failed++; $display("FAIL zero_slice10: got %h required %h", slice(10), ZERO_R10);
        end
    endtask

    task automatic test_ignore_start;
        int   f1, fcnt;
        logic busy_ok;
        f1 = -1; fcnt = 0; busy_ok = 1'b1;
        accept(FIPS_KEY);
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (finish === 1'b1) begin
                fcnt++;
                if (f1 < 0) f1 = i;
            end
            if (i <= 9 && busy !== 1'b1) busy_ok = 1'b0;
            if (i == 3) begin
                start = 1'b1;
                key   = ZERO_KEY;
            end
            if (i == 4) start = 1'b0;
        end
        tests_run++;
        if (f1 !== 10 || fcnt !== 1) begin
            tests_failed++; $display("FAIL ignore_finish: at %0d count %0d required at 10 count 1", f1, fcnt);
        end
        tests_run++;
        if (busy_ok !== 1'b1) begin
            tests_failed++; $display("FAIL ignore_busy: got %b required 1", busy_ok);
        end
        tests_run++;
        if (slice(1) !== FIPS_R1 || slice(10) !== FIPS_R10) begin
            tests_failed++; $display("FAIL ignore_result: slice10 %h required %h", slice(10), FIPS_R10);
        end
    endtask

    task automatic test_back_to_back;
        int           f1, f2, fcnt;
        logic [127:0] first_r10, second_r10, s1_restart, s0_restart;
        logic         busy_restart;
        f1 = -1; f2 = -1; fcnt = 0;
        first_r10 = '0; second_r10 = '0; s1_restart = '1; s0_restart = '0; busy_restart = 1'b0;
        @(negedge clk);
        key   = FIPS_KEY;
        start = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (finish === 1'b1) begin
                fcnt++;
                if (f1 < 0) f1 = i;
                else if (f2 < 0) f2 = i;
            end
            if (i == 10) first_r10 = slice(10);
            if (i == 11) begin
                s0_restart   = slice(0);
                s1_restart   = slice(1);
                busy_restart = busy;
            end
            if (i == 21) begin
                second_r10 = slice(10);
                start      = 1'b0;
            end
        end
        tests_run++;
        if (f1 !== 10 || f2 !== 21 || fcnt !== 2) begin
            tests_failed++; $display("FAIL b2b_finish: at %0d,%0d count %0d required 10,21 count 2", f1, f2, fcnt);
        end
        tests_run++;
        if (s1_restart !== 128'd0 || s0_restart !== FIPS_KEY || busy_restart !== 1'b1) begin
            tests_failed++; $display("FAIL b2b_restart: slice1 %h required 0", s1_restart);
        end
        tests_run++;
        if (first_r10 !== FIPS_R10 || second_r10 !== FIPS_R10) begin
            tests_failed++; $display("FAIL b2b_result: %h / %h required %h", first_r10, second_r10, FIPS_R10);
        end
    endtask

    task automatic test_abort;
        int f1, f2, fcnt, bdrop;
        accept(FIPS_KEY);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (expanded_key !== 1408'd0 || busy !== 1'b0 || finish !== 1'b0) begin
            tests_failed++; $display("FAIL abort_zero: busy %b finish %b slice0 %h required all 0", busy, finish, slice(0));
        end
        rst = 1'b1;
        watch(12, f1, f2, fcnt, bdrop);
        tests_run++;
        if (fcnt !== 0) begin
            tests_failed++; $display("FAIL abort_no_finish: count %0d required 0", fcnt);
        end
        accept(FIPS_KEY);
        watch(12, f1, f2, fcnt, bdrop);
        tests_run++;
        if (f1 !== 10 || slice(10) !== FIPS_R10) begin
            tests_failed++; $display("FAIL abort_rerun: finish at %0d slice10 %h required 10 %h", f1, slice(10), FIPS_R10);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst   = 1'b0;
        start = 1'b0;
        key   = 128'd0;
        test_reset;
        test_fips;
        test_idle_hold;
        test_zero_key;
        test_ignore_start;
        test_back_to_back;
        test_abort;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/key_expansion.md
KEY_EXPANSION -- requirements
Module: key_expansion

Interface
REQ-001 The block SHALL have no parameters; AES-128 only (Nk=4, Nr=10, 44 words).
REQ-002 clk  input  1  single clock; all state updates SHALL occur on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request to expand `key`; sampled only in IDLE.
REQ-005 key  input  128  cipher key; w0 = key[127:96], w3 = key[31:0].
REQ-006 expanded_key  output  1408  round keys; round r SHALL occupy bits [r*128+127 : r*128], round 0 at [127:0], word order within a slice as for `key`.
REQ-007 busy  output  1  high while expansion is in progress.
REQ-008 finish  output  1  one-cycle pulse when all 11 round keys are valid.

Function
REQ-009 The block SHALL implement the FSM states IDLE and EXPAND plus a 4-bit round counter rc.
REQ-010 IDLE with start=1 at edge T: latch key into slice 0, clear slices 1..10 to 0, set rc=1, busy=1, and go to EXPAND.
REQ-011 IDLE with start=0: all outputs hold, except finish, which SHALL be 0.
REQ-012 EXPAND, each edge: compute slice rc from slice rc-1 per FIPS-197, write it, then rc=rc+1; exactly one round key SHALL be produced per cycle.
REQ-013 Round step: t = SubWord(RotWord(w3_prev)) ^ {Rcon[rc],24'h0}; w0 = w0_prev^t; w1 = w1_prev^w0; w2 = w2_prev^w1; w3 = w3_prev^w2.
REQ-014 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex); RotWord SHALL rotate the word left by one byte.
REQ-015 SubWord SHALL apply the FIPS-197 forward S-box to each of the 4 bytes, implemented combinationally inside this block.
REQ-016 At the edge that writes slice 10 (edge T+10): finish<=1, busy<=0, state<=IDLE, rc<=0.
REQ-017 finish SHALL be high for exactly the cycle following edge T+10 and SHALL return to 0 at the next edge.
REQ-018 Latency: start accepted at edge T SHALL result in finish observed high from T+10 to T+11.
REQ-019 start while busy=1 SHALL be ignored; key changes during EXPAND SHALL not affect the result, because only the latched slice 0 is used.
REQ-020 start=1 in the finish cycle SHALL be accepted (back-to-back), restarting at REQ-010.
REQ-021 expanded_key SHALL hold its value after finish until the next accepted start.
REQ-022 rc SHALL never exceed 10; there SHALL be no wrap-around into slice 11.

Reset
REQ-023 rst=0 at an edge SHALL set expanded_key=0, busy=0, finish=0, rc=0, state=IDLE, overriding start.
REQ-024 rst=0 mid-expansion SHALL abort the expansion: no finish pulse and outputs zeroed; the next start after release SHALL run a full expansion.
REQ-025 A start asserted in the same cycle as rst=0 SHALL be lost.

Verification
REQ-026 key=2b7e151628aed2a6abf7158809cf4f3c, start pulse -> finish 10 cycles later; slice1=a0fafe1788542cb123a339392a6c7605, slice10=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-027 key=0, start -> slice1=62636363626363636263636362636363, slice10=b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-028 Start at T, second start and key change at T+4 -> single finish at T+10 with the first key's results; busy high for T..T+10.
REQ-029 Back-to-back: start held high continuously with the FIPS key -> finish pulses at T+10 and T+21, identical results each time.
REQ-030 rst=0 at T+5 during expansion -> all outputs 0, no finish; after release, start -> correct result 10 cycles later.
REQ-031 Idle 20 cycles after finish with start=0 -> expanded_key unchanged, finish=0, busy=0.
